fft_frame_unloader: RTL and testbench
=====================================

// Module: fft_frame_unloader
// PURPOSE
//  Downstream neighbour of the 1024-point parallel FFT core. Captures one full
//  WIDTH*N result frame (real+imag) in a single handshake, then streams it out
//  one complex sample per beat on a valid/ready interface. Optionally undoes
//  the core's bit-reversed output order, so bins leave in natural order 0..N-1.
// PARAMETERS
//  WIDTH        16    bits per real/imag sample (two's complement, passed through)
//  N            1024  samples per frame (power of two, >=2)
//  LOG2N        10    log2(N); index/counter width
//  BIT_REVERSE  1     1: read frame position bitrev(cnt); 0: read position cnt
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  frame_valid  in   1           frame_real/frame_imag hold a complete FFT result
//  frame_ready  out  1           unloader accepts frame this cycle
//  frame_real   in   WIDTH*N     sample p at [WIDTH*p +: WIDTH]
//  frame_imag   in   WIDTH*N     same packing as frame_real
//  m_valid      out  1           output beat valid
//  m_ready      in   1           downstream accepts beat
//  m_real       out  WIDTH       real part of current bin
//  m_imag       out  WIDTH       imag part of current bin
//  m_index      out  LOG2N       bin number of current beat (= cnt)
//  m_last       out  1           high on the beat with m_index==N-1
//  frame_count  out  16          frames fully streamed since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  - One clock domain, one clock. Reset is asynchronous, active-low; state
//    clears immediately on rst_n falling edge, regardless of clk.
//  - Reset values: state=IDLE, cnt=0, m_valid=0, m_real=0, m_imag=0,
//    m_index=0, m_last=0, frame_count=0. frame_ready=1 after reset.
//    Frame buffer is not reset.
//  - FSM IDLE: frame_ready=1, m_valid=0.
//    On frame_valid&&frame_ready: latch both vectors into buffer, cnt<=0, ->STREAM.
//  - FSM STREAM: m_valid=1. Read address a = BIT_REVERSE ? bitrev(cnt) : cnt.
//    m_real=buf_real[a], m_imag=buf_imag[a], m_index=cnt, m_last=(cnt==N-1).
//  - Latency: first beat has m_valid=1 on the cycle after frame acceptance.
//  - Beat transfer: m_valid&&m_ready. On transfer with cnt<N-1: cnt<=cnt+1.
//    On transfer with cnt==N-1: frame_count<=frame_count+1, ->IDLE,
//    unless a new frame is accepted in the same cycle (see back-to-back).
//  - Stall: while m_valid&&!m_ready, all m_* outputs are held stable.
//    cnt does not advance. m_valid is never deasserted mid-frame.
//  - m_real/m_imag/m_index/m_last are forced to 0 whenever m_valid=0.
//  - frame_ready = (state==IDLE) | (state==STREAM & cnt==N-1 & m_ready).
//    This is the only combinational in->out path (m_ready->frame_ready).
//  - Back-to-back: a frame accepted on the last-beat transfer cycle reloads the
//    buffer and sets cnt<=0. FSM stays in STREAM. Bin 0 of the new frame is
//    presented next cycle with no bubble. frame_count still increments.
//  - frame_valid while frame_ready=0: ignored. The upstream must hold it
//    (no data loss, no error flag).
//  - Reset mid-frame: the in-progress frame is discarded. Outputs take reset
//    values immediately. No partial frame is counted.
//  - Arithmetic: samples pass through bit-exact; no scaling, rounding or
//    sign change. cnt is LOG2N bits. frame_count is a 16-bit wrapping counter.
// TESTING (bench uses N=8, LOG2N=3, WIDTH=16 unless stated)
//  1 Assert rst_n=0 with random inputs -> m_valid=0, m_real=m_imag=0,
//    frame_ready=1, frame_count=0. Check both async-assert and release.
//  2 BIT_REVERSE=0, real[p]=p, imag[p]=-p, m_ready=1 -> 8 consecutive beats,
//    m_real=0..7, m_imag=0,-1..-7, m_index=0..7, m_last only on beat 7,
//    first beat 1 cycle after accept, frame_count=1.
//  3 BIT_REVERSE=1, real[p]=p -> m_real sequence 0,4,2,6,1,5,3,7 with
//    m_index 0..7. Repeat with N=1024: beat k carries real[bitrev10(k)].
//  4 Backpressure: m_ready pattern 1,0,0,1,0,1... -> each bin delivered
//    exactly once, in order. Outputs stable on every stalled cycle.
//  5 Back-to-back: frame B valid during frame A's last beat, with m_ready=1
//    -> frame_ready=1 that cycle. B bin 0 appears the next cycle, no gap.
//    frame_count=2 after B completes.
//  6 Drop rst_n at beat 3 of a frame -> outputs 0 asynchronously. After
//    release, frame_ready=1 and frame_count=0. A new frame then streams all
//    8 beats correctly.

Source files
------------

// File: rtl/fft_frame_unloader.sv
// fft_frame_unloader
//   Captures a whole FFT result frame (N complex samples) in one handshake and
//   streams it out one complex sample per beat. With BIT_REVERSE set, beat k
//   reads the buffered sample at position bitrev(k), which undoes the core's
//   bit-reversed output order so that bins leave as 0..N-1.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   frame_valid/frame_ready frame handshake; sample p at [WIDTH*p +: WIDTH]
//   frame_real, frame_imag  packed frame input
//   m_valid/m_ready         output beat handshake
//   m_real, m_imag          current bin (zero while m_valid is low)
//   m_index, m_last         bin number, high on bin N-1
//   frame_count             frames fully streamed since reset (wraps)
module fft_frame_unloader #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned N           = 1024,
  parameter int unsigned LOG2N       = 10,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [WIDTH*N-1:0]   frame_real,
  input  logic [WIDTH*N-1:0]   frame_imag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_real,
  output logic [WIDTH-1:0]     m_imag,
  output logic [LOG2N-1:0]     m_index,
  output logic                 m_last,
  output logic [15:0]          frame_count
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  localparam logic [LOG2N-1:0] CntLast = LOG2N'(N - 1);

  logic [0:0]         state_q, state_d;
  logic [LOG2N-1:0]   cnt_q, cnt_d;
  logic [15:0]        fc_q, fc_d;
  logic [WIDTH*N-1:0] buf_real_q, buf_imag_q;

  logic               cnt_last;
  logic               accept;
  logic               beat_xfer;
  logic [LOG2N-1:0]   rd_addr;

  always_comb begin
    cnt_last    = (cnt_q == CntLast);
    // Ready on the final beat only if that beat actually leaves this cycle,
    // so a waiting frame can be taken without a bubble.
    frame_ready = (state_q == StIdle) | ((state_q == StStream) & cnt_last & m_ready);
    accept      = frame_valid & frame_ready;
    beat_xfer   = (state_q == StStream) & m_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    if (beat_xfer) begin
      if (cnt_last) begin
        fc_d    = fc_q + 16'd1;
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + LOG2N'(1);
      end
    end
    // A frame taken on the last beat keeps the stream running from bin 0.
    if (accept) begin
      state_d = StStream;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
    end
  end

  // Frame buffer carries no reset; it is only read while streaming a frame
  // that has been loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_real_q <= frame_real;
      buf_imag_q <= frame_imag;
    end
  end

  always_comb begin
    rd_addr = cnt_q;
    if (BIT_REVERSE) begin
      for (int i = 0; i < int'(LOG2N); i++) begin
        rd_addr[i] = cnt_q[int'(LOG2N) - 1 - i];
      end
    end
  end

  // Outputs derive from held state only, so they stay stable under stall.
  always_comb begin
    m_valid     = (state_q == StStream);
    m_real      = '0;
    m_imag      = '0;
    m_index     = '0;
    m_last      = 1'b0;
    frame_count = fc_q;
    if (m_valid) begin
      m_real  = buf_real_q[int'(rd_addr) * int'(WIDTH) +: WIDTH];
      m_imag  = buf_imag_q[int'(rd_addr) * int'(WIDTH) +: WIDTH];
      m_index = cnt_q;
      m_last  = cnt_last;
    end
  end

endmodule

// File: tb/tb_fft_frame_unloader.sv
module tb_fft_frame_unloader;

  localparam int W  = 16;
  localparam int NS = 8;
  localparam int NB = 1024;

  logic clk;
  logic rst_n;

  // Shared stimulus for the two N=8 instances (natural and bit-reversed)
  logic            frame_valid;
  logic [W*NS-1:0] frame_real, frame_imag;
  logic            m_ready;

  logic        fr_a, mv_a, last_a, fr_b, mv_b, last_b;
  logic [15:0] mr_a, mi_a, fc_a, mr_b, mi_b, fc_b;
  logic [2:0]  idx_a, idx_b;

  // N=1024 bit-reversed instance
  logic            fv_big, fr_big, mv_big, mready_big, last_big;
  logic [W*NB-1:0] real_big, imag_big;
  logic [15:0]     mr_big, mi_big, fc_big;
  logic [9:0]      idx_big;

  fft_frame_unloader #(.WIDTH(W), .N(NS), .LOG2N(3), .BIT_REVERSE(1'b0)) dut_nat (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(fr_a),
    .frame_real(frame_real), .frame_imag(frame_imag), .m_valid(mv_a), .m_ready(m_ready),
    .m_real(mr_a), .m_imag(mi_a), .m_index(idx_a), .m_last(last_a), .frame_count(fc_a));

  fft_frame_unloader #(.WIDTH(W), .N(NS), .LOG2N(3), .BIT_REVERSE(1'b1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(fr_b),
    .frame_real(frame_real), .frame_imag(frame_imag), .m_valid(mv_b), .m_ready(m_ready),
    .m_real(mr_b), .m_imag(mi_b), .m_index(idx_b), .m_last(last_b), .frame_count(fc_b));

  fft_frame_unloader #(.WIDTH(W), .N(NB), .LOG2N(10), .BIT_REVERSE(1'b1)) dut_big (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv_big), .frame_ready(fr_big),
    .frame_real(real_big), .frame_imag(imag_big), .m_valid(mv_big), .m_ready(mready_big),
    .m_real(mr_big), .m_imag(mi_big), .m_index(idx_big), .m_last(last_big),
    .frame_count(fc_big));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference bit reversal by arithmetic
  function automatic int unsigned rev(input int unsigned v, input int unsigned bits);
    int unsigned r = 0;
    int unsigned x = v;
    for (int i = 0; i < int'(bits); i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  typedef struct {
    logic [15:0] re_nat, im_nat, re_rev, im_rev;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0] re, im;
    logic [9:0]  idx;
    logic        last;
  } bbeat_t;

  beat_t       q[$];
  bbeat_t      qb[$];
  logic [15:0] fc_exp;
  logic [15:0] fcb_exp;
  int          dut_b2b = 0;

  // m_ready generator: 0 always-ready, 1 random, 2 fixed pattern 1,0,0,1,0,1
  int          rdy_mode = 1;
  int          pat_ptr  = 0;
  logic [5:0]  pat      = 6'b101001;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      2: begin
        m_ready = pat[pat_ptr];
        pat_ptr = (pat_ptr + 1) % 6;
      end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    mready_big = 1'($urandom_range(0, 1));
  end

  function automatic void check_reset_state();
    check("rst_mvalid_nat", mv_a, 0);
    check("rst_mvalid_rev", mv_b, 0);
    check("rst_mreal_nat", mr_a, 0);
    check("rst_mimag_nat", mi_a, 0);
    check("rst_mreal_rev", mr_b, 0);
    check("rst_mindex", idx_a, 0);
    check("rst_mlast", last_a, 0);
    check("rst_fready_nat", fr_a, 1);
    check("rst_fready_rev", fr_b, 1);
    check("rst_fcount_nat", fc_a, 0);
    check("rst_fcount_rev", fc_b, 0);
    check("rst_mvalid_big", mv_big, 0);
  endfunction

  // Monitor/scoreboard for the N=8 pair
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      fc_exp = '0;
      check_reset_state();
    end else begin
      logic  exp_valid, exp_ready;
      beat_t e;
      exp_valid = (q.size() != 0);
      exp_ready = !exp_valid || (q.size() == 1 && m_ready);
      check("frame_ready_nat", fr_a, exp_ready);
      check("frame_ready_rev", fr_b, exp_ready);
      check("m_valid_nat", mv_a, exp_valid);
      check("m_valid_rev", mv_b, exp_valid);
      check("frame_count_nat", fc_a, fc_exp);
      check("frame_count_rev", fc_b, fc_exp);
      if (exp_valid) begin
        e = q[0];
        check("m_real_nat", mr_a, e.re_nat);
        check("m_imag_nat", mi_a, e.im_nat);
        check("m_real_rev", mr_b, e.re_rev);
        check("m_imag_rev", mi_b, e.im_rev);
        check("m_index_nat", idx_a, e.idx);
        check("m_index_rev", idx_b, e.idx);
        check("m_last_nat", last_a, e.last);
        check("m_last_rev", last_b, e.last);
      end else begin
        check("idle_zero_nat", {mr_a, mi_a, 13'(idx_a), last_a}, 0);
        check("idle_zero_rev", {mr_b, mi_b, 13'(idx_b), last_b}, 0);
      end
      if (mv_a && fr_a && frame_valid) dut_b2b++;
      // Advance the model across the coming clock edge
      if (exp_valid && m_ready) begin
        e = q.pop_front();
        if (e.last) fc_exp = fc_exp + 16'd1;
      end
      if (frame_valid && exp_ready) begin
        for (int k = 0; k < NS; k++) begin
          beat_t nb;
          int unsigned r;
          r = rev(k, 3);
          nb.re_nat = frame_real[W*k +: W];
          nb.im_nat = frame_imag[W*k +: W];
          nb.re_rev = frame_real[W*int'(r) +: W];
          nb.im_rev = frame_imag[W*int'(r) +: W];
          nb.idx    = 3'(k);
          nb.last   = (k == NS - 1);
          q.push_back(nb);
        end
      end
    end
  end

  // Monitor/scoreboard for the N=1024 instance
  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      fcb_exp = '0;
    end else begin
      logic   bv, br;
      bbeat_t e;
      bv = (qb.size() != 0);
      br = !bv || (qb.size() == 1 && mready_big);
      check("big_frame_ready", fr_big, br);
      check("big_m_valid", mv_big, bv);
      check("big_frame_count", fc_big, fcb_exp);
      if (bv) begin
        e = qb[0];
        check("big_m_real", mr_big, e.re);
        check("big_m_imag", mi_big, e.im);
        check("big_m_index", idx_big, e.idx);
        check("big_m_last", last_big, e.last);
        if (mready_big) begin
          e = qb.pop_front();
          if (e.last) fcb_exp = fcb_exp + 16'd1;
        end
      end
      if (fv_big && br) begin
        for (int k = 0; k < NB; k++) begin
          bbeat_t nb;
          int unsigned r;
          r = rev(k, 10);
          nb.re   = real_big[W*int'(r) +: W];
          nb.im   = imag_big[W*int'(r) +: W];
          nb.idx  = 10'(k);
          nb.last = (k == NB - 1);
          qb.push_back(nb);
        end
      end
    end
  end

  // Present a frame (0: real=p, imag=-p; 1: random) and hold until taken
  task automatic send_frame(input int mode);
    logic acc;
    for (int p = 0; p < NS; p++) begin
      if (mode == 0) begin
        frame_real[W*p +: W] = 16'(p);
        frame_imag[W*p +: W] = 16'(-p);
      end else begin
        frame_real[W*p +: W] = 16'($urandom);
        frame_imag[W*p +: W] = 16'($urandom);
      end
    end
    frame_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = fr_a;
      @(posedge clk);
      #1;
    end
    frame_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while (q.size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (q.size() != 0) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   base;
    logic hit;
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    frame_real  = '0;
    frame_imag  = '0;
    m_ready     = 1'b0;
    fv_big      = 1'b0;
    real_big    = '0;
    imag_big    = '0;
    mready_big  = 1'b0;

    // Reset with random inputs toggling
    repeat (4) begin
      @(posedge clk);
      #1;
      frame_valid = 1'($urandom_range(0, 1));
      frame_real  = {4{32'($urandom)}};
      fv_big      = 1'($urandom_range(0, 1));
    end
    frame_valid = 1'b0;
    fv_big      = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("release_fready", fr_a, 1);
    check("release_fcount", fc_a, 0);
    check("release_mvalid", mv_a, 0);
    @(posedge clk);
    #1;

    // Ramp frame, always ready
    rdy_mode = 0;
    send_frame(0);
    wait_drain();

    // Backpressure pattern
    rdy_mode = 2;
    send_frame(1);
    wait_drain();

    // Back-to-back frames
    rdy_mode = 0;
    base = dut_b2b;
    send_frame(1);
    send_frame(1);
    wait_drain();
    check("b2b_accepts", dut_b2b - base, 1);

    // Reset mid-frame at beat 3
    rdy_mode = 1;
    send_frame(1);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = mv_a && (idx_a == 3'd3);
    end
    if (!hit) check("beat3_timeout", 0, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_state();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rerelease_fready", fr_a, 1);
    check("rerelease_fcount", fc_a, 0);
    send_frame(1);
    wait_drain();

    // Random soak, some frames back-to-back
    for (int f = 0; f < 6; f++) begin
      send_frame(1);
      if ($urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();

    // N=1024 bit-reversed frame
    for (int p = 0; p < NB; p++) begin
      real_big[W*p +: W] = 16'($urandom);
      imag_big[W*p +: W] = 16'($urandom);
    end
    fv_big = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      hit = fr_big;
      @(posedge clk);
      #1;
    end
    fv_big = 1'b0;
    if (!hit) check("big_accept_timeout", 0, 1);
    for (int c = 0; c < 8000 && qb.size() != 0; c++) @(negedge clk);
    if (qb.size() != 0) check("big_drain_timeout", 0, 1);
    @(negedge clk);
    check("big_final_count", fc_big, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
